// File: rtl/uart_fb_loader.sv
// uart_fb_loader
//   Converts the raw grayscale byte stream from the UART receiver into
//   framebuffer writes for the dual-port frame RAM of the LED panel driver.
//   Bytes arrive column-major (y fastest). Each byte's (x,y) position is
//   remapped into the panel's interleaved framebuffer layout. An idle gap
//   of TIMEOUT cycles resynchronises the position to (0,0). One ACK_BYTE
//   is sent back to the UART transmitter per completed frame.
//
// Ports
//   clk          system clock (48 MHz)
//   reset        asynchronous active-low reset
//   rx_data      received UART byte
//   rx_strobe    one-cycle pulse, rx_data valid
//   wr_enable    framebuffer write strobe (one cycle per received byte)
//   wr_addr      framebuffer write address
//   wr_data      framebuffer write data
//   tx_data      byte to UART transmitter
//   tx_strobe    one-cycle pulse, tx_data valid
//   frame_count  completed frames, wraps 255->0
//   activity_n   low while wr_enable is high (drives led_r)
//
// State table
//   state     | meaning
//   WAIT_BYTE | no byte accepted last cycle; idle counter running
//   WRITE     | write (and possibly ack) issued this cycle; a new strobe
//             | may be accepted in the same cycle
module uart_fb_loader #(
    parameter int          WIDTH         = 128,
    parameter int          HEIGHT        = 32,
    parameter int          FB_ADDR_WIDTH = 13,
    parameter int          TIMEOUT       = 48000,
    parameter logic [7:0]  ACK_BYTE      = 8'h0A
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               rx_data,
    input  logic                     rx_strobe,
    output logic                     wr_enable,
    output logic [FB_ADDR_WIDTH-1:0] wr_addr,
    output logic [7:0]               wr_data,
    output logic [7:0]               tx_data,
    output logic                     tx_strobe,
    output logic [7:0]               frame_count,
    output logic                     activity_n
);

    localparam int         CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] IDLE_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] IDLE_PRE = CNT_W'(TIMEOUT - 2);
    localparam logic [7:0] X_LAST   = 8'(WIDTH - 1);
    localparam logic [4:0] Y_LAST   = 5'(HEIGHT - 1);

    typedef enum logic {
        WAIT_BYTE = 1'b0,
        WRITE     = 1'b1
    } state_t;

    state_t state, state_next;

    logic [7:0]               x, x_next;
    logic [4:0]               y, y_next;
    logic [CNT_W-1:0]         idle_cnt, idle_cnt_next;

    logic                     wr_enable_next;
    logic [FB_ADDR_WIDTH-1:0] wr_addr_next;
    logic [7:0]               wr_data_next;
    logic [7:0]               tx_data_next;
    logic                     tx_strobe_next;
    logic [7:0]               frame_count_next;
    logic                     activity_n_next;

    // addr = x[3:0]*384 + x[7:4]*48 + offset, built from shifts and adds.
    // Rows 0..15 live in the upper half of each 48-entry column group.
    function automatic logic [FB_ADDR_WIDTH-1:0] remap(input logic [7:0] xp,
                                                        input logic [4:0] yp);
        logic [13:0] lo;
        logic [13:0] hi;
        logic [13:0] off;
        logic [13:0] sum;
        lo  = {10'd0, xp[3:0]};
        hi  = {10'd0, xp[7:4]};
        off = yp[4] ? {9'd0, yp} : ({9'd0, yp} + 14'd32);
        sum = (lo << 8) + (lo << 7) + (hi << 5) + (hi << 4) + off;
        return FB_ADDR_WIDTH'(sum);
    endfunction

    always_comb begin
        state_next       = state;
        x_next           = x;
        y_next           = y;
        idle_cnt_next    = idle_cnt;
        wr_addr_next     = wr_addr;
        wr_data_next     = wr_data;
        tx_data_next     = tx_data;
        tx_strobe_next   = 1'b0;
        frame_count_next = frame_count;

        case (state)
            WAIT_BYTE: state_next = rx_strobe ? WRITE : WAIT_BYTE;
            WRITE:     state_next = rx_strobe ? WRITE : WAIT_BYTE;
            default:   state_next = WAIT_BYTE;
        endcase

        if (rx_strobe) begin
            // A strobe always wins over a coincident timeout.
            idle_cnt_next = '0;
            wr_addr_next  = remap(x, y);
            wr_data_next  = rx_data;
            if (y == Y_LAST) begin
                y_next = '0;
                if (x == X_LAST) begin
                    x_next           = '0;
                    tx_strobe_next   = 1'b1;
                    tx_data_next     = ACK_BYTE;
                    frame_count_next = frame_count + 8'd1;
                end else begin
                    x_next = x + 8'd1;
                end
            end else begin
                y_next = y + 5'd1;
            end
        end else if (idle_cnt != IDLE_MAX) begin
            idle_cnt_next = idle_cnt + 1'b1;
            if (idle_cnt == IDLE_PRE) begin
                x_next = '0;
                y_next = '0;
            end
        end

        wr_enable_next  = (state_next == WRITE);
        activity_n_next = (state_next != WRITE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= WAIT_BYTE;
            x           <= '0;
            y           <= '0;
            idle_cnt    <= '0;
            wr_enable   <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            tx_data     <= '0;
            tx_strobe   <= 1'b0;
            frame_count <= '0;
            activity_n  <= 1'b1;
        end else begin
            state       <= state_next;
            x           <= x_next;
            y           <= y_next;
            idle_cnt    <= idle_cnt_next;
            wr_enable   <= wr_enable_next;
            wr_addr     <= wr_addr_next;
            wr_data     <= wr_data_next;
            tx_data     <= tx_data_next;
            tx_strobe   <= tx_strobe_next;
            frame_count <= frame_count_next;
            activity_n  <= activity_n_next;
        end
    end

endmodule

// File: tb/tb_uart_fb_loader.sv
module tb_uart_fb_loader;

    localparam int TO = 64;

    logic        clk;
    logic        reset;
    logic [7:0]  rx_data,  rx_data_b;
    logic        rx_strobe, rx_strobe_b;

    logic        wr_enable,  wr_enable_b;
    logic [12:0] wr_addr,    wr_addr_b;
    logic [7:0]  wr_data,    wr_data_b;
    logic [7:0]  tx_data,    tx_data_b;
    logic        tx_strobe,  tx_strobe_b;
    logic [7:0]  frame_count, frame_count_b;
    logic        activity_n, activity_n_b;

    uart_fb_loader #(.WIDTH(128), .HEIGHT(32), .FB_ADDR_WIDTH(13),
                     .TIMEOUT(TO), .ACK_BYTE(8'h0A)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_strobe(rx_strobe),
        .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
        .tx_data(tx_data), .tx_strobe(tx_strobe), .frame_count(frame_count),
        .activity_n(activity_n)
    );

    // Narrow frame (4 columns) so 256 frames fit a short run.
    uart_fb_loader #(.WIDTH(4), .HEIGHT(32), .FB_ADDR_WIDTH(13),
                     .TIMEOUT(TO), .ACK_BYTE(8'h0A)) dut_b (
        .clk(clk), .reset(reset), .rx_data(rx_data_b), .rx_strobe(rx_strobe_b),
        .wr_enable(wr_enable_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .tx_data(tx_data_b), .tx_strobe(tx_strobe_b), .frame_count(frame_count_b),
        .activity_n(activity_n_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_seen  = 0;
    int ack_seen = 0;
    int ack_b    = 0;

    always @(negedge clk) begin
        if (wr_enable)   wr_seen++;
        if (tx_strobe)   ack_seen++;
        if (tx_strobe_b) ack_b++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Strobe one byte at a negedge; return at the next negedge with its write visible.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data   = b;
        rx_strobe = 1'b1;
        @(negedge clk);
        rx_strobe = 1'b0;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
    endtask

    typedef struct {
        int          idx;
        logic [12:0] addr;
        logic        ack;
        logic [7:0]  fc;
    } vec_t;

    vec_t vecs[9];

    initial begin
        int sent;
        reset = 1'b1; rx_data = '0; rx_strobe = 1'b0; rx_data_b = '0; rx_strobe_b = 1'b0;

        vecs[0] = '{0,    13'd32,   1'b0, 8'd0};
        vecs[1] = '{1,    13'd33,   1'b0, 8'd0};
        vecs[2] = '{16,   13'd16,   1'b0, 8'd0};
        vecs[3] = '{32,   13'd416,  1'b0, 8'd0};
        vecs[4] = '{47,   13'd431,  1'b0, 8'd0};
        vecs[5] = '{512,  13'd80,   1'b0, 8'd0};
        vecs[6] = '{2048, 13'd224,  1'b0, 8'd0};
        vecs[7] = '{4095, 13'd6127, 1'b1, 8'd1};
        vecs[8] = '{4096, 13'd32,   1'b0, 8'd1};

        // Reset state
        #2 reset = 1'b0;
        #3;
        chk("rst wr_enable",   wr_enable,   0);
        chk("rst wr_addr",     wr_addr,     0);
        chk("rst wr_data",     wr_data,     0);
        chk("rst tx_data",     tx_data,     0);
        chk("rst tx_strobe",   tx_strobe,   0);
        chk("rst frame_count", frame_count, 0);
        chk("rst activity_n",  activity_n,  1);
        @(negedge clk);
        reset = 1'b1;

        // First byte, one-cycle latency and single-cycle strobe
        send_byte(8'h55);
        chk("b0 wr_enable",  wr_enable,  1);
        chk("b0 wr_addr",    wr_addr,    32);
        chk("b0 wr_data",    wr_data,    8'h55);
        chk("b0 activity_n", activity_n, 0);
        @(negedge clk); #1;
        chk("b0 wr_enable drop",  wr_enable,  0);
        chk("b0 activity_n rise", activity_n, 1);

        // Table-driven remap walk through a full frame
        do_reset();
        ack_seen = 0;
        sent = 0;
        for (int v = 0; v < 9; v++) begin
            while (sent < vecs[v].idx) begin
                send_byte(8'(sent));
                sent++;
            end
            send_byte(8'(sent) ^ 8'hA5);
            sent++;
            chk($sformatf("v%0d wr_enable", vecs[v].idx),   wr_enable,   1);
            chk($sformatf("v%0d wr_addr", vecs[v].idx),     wr_addr,     vecs[v].addr);
            chk($sformatf("v%0d wr_data", vecs[v].idx),     wr_data,     8'(vecs[v].idx) ^ 8'hA5);
            chk($sformatf("v%0d tx_strobe", vecs[v].idx),   tx_strobe,   vecs[v].ack);
            chk($sformatf("v%0d frame_count", vecs[v].idx), frame_count, vecs[v].fc);
            if (vecs[v].ack) chk("ack tx_data", tx_data, 8'h0A);
        end
        chk("frame ack count", ack_seen, 1);

        // Idle timeout resync
        do_reset();
        ack_seen = 0;
        wr_seen = 0;
        for (int i = 0; i < 40; i++) send_byte(8'(i));
        repeat (TO - 1) @(negedge clk);
        #1;
        chk("timeout no write", wr_seen, 40);
        send_byte(8'hC3);
        chk("timeout addr", wr_addr, 32);
        chk("timeout no ack", ack_seen, 0);
        chk("timeout frame_count", frame_count, 0);

        do_reset();
        for (int i = 0; i < 40; i++) send_byte(8'(i));
        repeat (TO - 3) @(negedge clk);
        send_byte(8'h3C);
        chk("short idle addr", wr_addr, 424);
        chk("short idle data", wr_data, 8'h3C);

        // Back-to-back strobes
        do_reset();
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rx_data = 8'(8'h10 + i);
            rx_strobe = 1'b1;
            @(negedge clk); #1;
            chk($sformatf("b2b%0d wr_enable", i), wr_enable, 1);
            chk($sformatf("b2b%0d wr_addr", i),   wr_addr,   32 + i);
            chk($sformatf("b2b%0d wr_data", i),   wr_data,   8'h10 + i);
        end
        rx_strobe = 1'b0;
        for (int i = 0; i < 5; i++) send_byte(8'hE0);
        chk("pre-reset wr_enable", wr_enable, 1);
        reset = 1'b0;
        #1;
        chk("async wr_enable",  wr_enable,  0);
        chk("async wr_addr",    wr_addr,    0);
        chk("async wr_data",    wr_data,    0);
        chk("async activity_n", activity_n, 1);
        @(negedge clk);
        reset = 1'b1;
        send_byte(8'h77);
        chk("post-reset addr", wr_addr, 32);

        // 256 frames on the narrow instance (128 bytes per frame)
        do_reset();
        ack_b = 0;
        @(negedge clk);
        rx_strobe_b = 1'b1;
        rx_data_b = 8'h11;
        repeat (128) @(negedge clk);
        #1;
        chk("b frame1 tx_strobe",   tx_strobe_b,   1);
        chk("b frame1 frame_count", frame_count_b, 1);
        chk("b frame1 wr_addr",     wr_addr_b,     6'd31 + 13'd384 * 3);
        repeat (256 * 128 - 128) @(negedge clk);
        rx_strobe_b = 1'b0;
        #1;
        chk("b acks",        ack_b,         256);
        chk("b frame_count", frame_count_b, 0);
        @(negedge clk); #1;
        chk("b idle wr_enable", wr_enable_b, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_fb_loader.md
Name: uart_fb_loader

Overview:
Upstream stage of the LED panel driver. Receives a raw grayscale pixel stream from the UART receiver and converts it into framebuffer writes for the dual-port frame RAM.
- Tracks the (x,y) position of each byte and remaps it into the panel's interleaved framebuffer layout.
- Resynchronises to the start of frame on an idle gap.
- Emits one acknowledge byte per completed frame to the UART transmitter.

Parameters:
- WIDTH, 128: pixel columns per frame; x counts 0..WIDTH-1.
- HEIGHT, 32: pixel rows per frame; y counts 0..HEIGHT-1; must be 32 for the remap below.
- FB_ADDR_WIDTH, 13: framebuffer address width.
- TIMEOUT, 48000: idle clk cycles with no byte before position resets to (0,0); 1 ms at 48 MHz.
- ACK_BYTE, 8'h0A: byte sent on completion of each frame.

Ports:
- clk  in  1  system clock, 48 MHz.
- reset  in  1  asynchronous, active-low reset.
- rx_data  in  8  received UART byte.
- rx_strobe  in  1  one-cycle pulse; rx_data valid this cycle.
- wr_enable  out  1  framebuffer write strobe.
- wr_addr  out  FB_ADDR_WIDTH  framebuffer write address.
- wr_data  out  8  framebuffer write data.
- tx_data  out  8  byte to UART transmitter.
- tx_strobe  out  1  one-cycle pulse; tx_data valid.
- frame_count  out  8  completed frames, wraps 255->0.
- activity_n  out  1  low for the cycle wr_enable is high, else high; drives led_r.

Behaviour:
- Reset (reset low, asynchronous): all outputs and state cleared immediately.
  - wr_enable=0, wr_addr=0, wr_data=0, tx_data=0, tx_strobe=0, frame_count=0, activity_n=1.
  - x=0, y=0, idle counter=0.
  - Reset asserted mid-frame discards the current position. The first byte after release maps to (0,0).
- Scan order is column-major: y increments fastest.
  - After y=HEIGHT-1: y->0, x->x+1.
  - After (WIDTH-1, HEIGHT-1): x->0, y->0, frame complete.
- Remap, computed from (x,y) of the accepted byte:
  - offset = 32+y when y<16, else y.
  - addr = x[3:0]*384 + x[7:4]*48 + offset.
  - Implement with shifts and adds (384=256+128, 48=32+16); no multipliers.
  - The result must fit FB_ADDR_WIDTH. Maximum is 6143 for x=127, y=15.
- Latency: exactly 1 cycle.
  - A cycle with rx_strobe=1 produces, on the next cycle: wr_enable=1, wr_addr=remap(x,y), wr_data=rx_data, activity_n=0.
  - wr_enable is high for exactly one cycle per strobe.
  - Back-to-back strobes on consecutive cycles must each produce a write; no bytes dropped.
- Frame completion: the byte at (WIDTH-1, HEIGHT-1) causes the following on its wr_enable cycle:
  - tx_strobe=1 and tx_data=ACK_BYTE for one cycle.
  - frame_count increments.
  - No backpressure: the transmitter is idle between frames.
- Idle resync:
  - The idle counter increments on each cycle with rx_strobe=0 and clears on rx_strobe=1.
  - When the counter reaches TIMEOUT-1, x and y reset to 0 and the counter saturates until the next strobe.
  - No write, no ack and no frame_count change occur on timeout.
  - If rx_strobe and timeout coincide in the same cycle, the strobe wins: the byte is written at the current (x,y) and the counter clears.
- State machine: WAIT_BYTE -> WRITE (1 cycle, issues write and possible ack) -> WAIT_BYTE.
  - WRITE accepts a new strobe in the same cycle, so throughput is 1 byte/cycle.
- All outputs are registered; nothing is combinational from inputs.

Test Plan:
- Reset, then byte 0x55 -> next cycle wr_enable=1, wr_addr=32, wr_data=0x55, activity_n=0; the cycle after that, wr_enable=0.
- 17 bytes from reset -> 17th write (x=0,y=16) has wr_addr=16; the 33rd byte (x=1,y=0) has wr_addr=416.
- Byte at index 16*32 (x=16,y=0) -> wr_addr=80; byte at index 4095 (x=127,y=31) -> wr_addr=6127, tx_strobe=1, tx_data=0x0A, frame_count=1. The next byte maps to wr_addr=32.
- Send 40 bytes, idle TIMEOUT cycles, send byte -> wr_addr=32; no tx_strobe and frame_count unchanged. Idle of TIMEOUT-2 cycles instead -> next byte continues at (1,8), wr_addr=384+40=424.
- Strobes on 4 consecutive cycles -> 4 consecutive wr_enable cycles with addrs 32,33,34,35. Assert reset mid-stream -> outputs clear without waiting for a clock edge; next byte writes 32.
- Stream 256 full frames -> 256 acks; frame_count wraps to 0.
